sync_down_counter: RTL and testbench

Synchronous loadable down counter, the count-down counterpart of the lab's 4-bit up counter. Counts a parallel-loaded value down to zero and emits a one-cycle terminal-count pulse. Supports one-shot and auto-reload (periodic) modes. Used as a programmable delay/timeout or period generator beside the up counter.

---
 rtl/sync_down_counter.sv | 79 +++++++
 tb/tb_sync_down_counter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/sync_down_counter.sv
// Loadable down counter with one-shot and auto-reload modes.
// Emits a registered one-cycle terminal-count pulse when the count reaches zero or reloads.
module sync_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             enable,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q,     tc_d;
    logic             busy_q,   busy_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= ZERO;
            reload_q <= ZERO;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            busy_q   <= busy_d;
        end
    end

    // RUN is only ever entered with a nonzero count, so count_q==0 never occurs in RUN.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (load) begin
            count_d  = in;
            reload_d = in;
            state_d  = (in != ZERO) ? RUN : IDLE;
        end else if (state_q == RUN && enable) begin
            if (count_q > ONE) begin
                count_d = count_q - ONE;
            end else if (count_q == ONE) begin
                tc_d = 1'b1;
                if (auto_reload) begin
                    count_d = reload_q;
                end else begin
                    count_d = ZERO;
                    state_d = IDLE;
                end
            end
        end

        busy_d = (state_d == RUN);
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_sync_down_counter.sv
// Directed bench for sync_down_counter: reset, one-shot, auto-reload, gating, load priority, boundaries.
module tb_sync_down_counter;

    logic       clk;
    logic       reset;
    logic [3:0] in;
    logic       load;
    logic       enable;
    logic       auto_reload;
    logic [3:0] count;
    logic       tc;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    sync_down_counter #(.WIDTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .in          (in),
        .load        (load),
        .enable      (enable),
        .auto_reload (auto_reload),
        .count       (count),
        .tc          (tc),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [3:0] c, input logic t, input logic b);
        chk({tag, ".count"}, {28'd0, count}, {28'd0, c});
        chk({tag, ".tc"},    {31'd0, tc},    {31'd0, t});
        chk({tag, ".busy"},  {31'd0, busy},  {31'd0, b});
        $display("t=%0t %s count=%0d tc=%0b busy=%0b", $time, tag, count, tc, busy);
    endtask

    logic [3:0] ar_exp [10];

    initial begin
        reset = 1'b0; in = '0; load = 1'b0; enable = 1'b0; auto_reload = 1'b0;
        ar_exp = '{4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2};

        #3;
        chk3("reset_state", 4'd0, 1'b0, 1'b0);
        #7 reset = 1'b1;

        // One-shot from 4
        in = 4'd4; load = 1'b1; auto_reload = 1'b0; enable = 1'b1;
        tick(); chk3("os_load", 4'd4, 1'b0, 1'b1);
        load = 1'b0;
        tick(); chk3("os_3", 4'd3, 1'b0, 1'b1);
        tick(); chk3("os_2", 4'd2, 1'b0, 1'b1);
        tick(); chk3("os_1", 4'd1, 1'b0, 1'b1);
        tick(); chk3("os_tc", 4'd0, 1'b1, 1'b0);
        tick(); chk3("os_hold", 4'd0, 1'b0, 1'b0);

        // Auto-reload from 3
        in = 4'd3; load = 1'b1; auto_reload = 1'b1;
        tick(); chk3("ar_load", 4'd3, 1'b0, 1'b1);
        load = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk3($sformatf("ar_%0d", i), ar_exp[i], (ar_exp[i] == 4'd3), 1'b1);
        end

        // Enable gating from 5
        auto_reload = 1'b0; in = 4'd5; load = 1'b1;
        tick(); chk3("eg_load", 4'd5, 1'b0, 1'b1);
        load = 1'b0;
        enable = 1'b1; tick(); chk3("eg_e1", 4'd4, 1'b0, 1'b1);
        enable = 1'b0; tick(); chk3("eg_e0a", 4'd4, 1'b0, 1'b1);
        tick(); chk3("eg_e0b", 4'd4, 1'b0, 1'b1);
        enable = 1'b1; tick(); chk3("eg_3", 4'd3, 1'b0, 1'b1);
        tick(); chk3("eg_2", 4'd2, 1'b0, 1'b1);
        tick(); chk3("eg_1", 4'd1, 1'b0, 1'b1);
        tick(); chk3("eg_tc", 4'd0, 1'b1, 1'b0);

        // Load beats terminal count
        in = 4'd2; load = 1'b1;
        tick(); chk3("lp_load2", 4'd2, 1'b0, 1'b1);
        load = 1'b0;
        tick(); chk3("lp_1", 4'd1, 1'b0, 1'b1);
        in = 4'd9; load = 1'b1;
        tick(); chk3("lp_load9", 4'd9, 1'b0, 1'b1);
        in = 4'd0;
        tick(); chk3("lp_load0", 4'd0, 1'b0, 1'b0);
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); chk3($sformatf("lp_idle_%0d", i), 4'd0, 1'b0, 1'b0);
        end

        // Full-range one-shot from 15
        in = 4'd15; load = 1'b1;
        tick(); chk3("b15_load", 4'd15, 1'b0, 1'b1);
        load = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk3($sformatf("b15_%0d", i), 4'(15 - i), (i == 15), (i < 15));
        end
        tick(); chk3("b15_nowrap", 4'd0, 1'b0, 1'b0);

        // Auto-reload of 1: tc every enabled cycle
        in = 4'd1; load = 1'b1; auto_reload = 1'b1;
        tick(); chk3("r1_load", 4'd1, 1'b0, 1'b1);
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); chk3($sformatf("r1_%0d", i), 4'd1, 1'b1, 1'b1);
        end
        enable = 1'b0;
        tick(); chk3("r1_gated", 4'd1, 1'b0, 1'b1);

        // Asynchronous reset mid-count
        auto_reload = 1'b0; enable = 1'b1; in = 4'd7; load = 1'b1;
        tick(); chk3("rs_load", 4'd7, 1'b0, 1'b1);
        load = 1'b0;
        tick(); chk3("rs_6", 4'd6, 1'b0, 1'b1);
        tick(); chk3("rs_5", 4'd5, 1'b0, 1'b1);
        #2 reset = 1'b0;
        #1 chk3("rs_async", 4'd0, 1'b0, 1'b0);
        #1 reset = 1'b1;
        tick(); chk3("rs_after", 4'd0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
